// File: rtl/ddr4_bank_monitor_if.sv
// DDR4 command/address bus as seen by a passive monitor.
// The master modport drives the bus; the slave modport only observes it.
interface ddr4_bank_monitor_if #(
  parameter int NUM_RANKS = 1,
  parameter int BG_BITS   = 1,
  parameter int BA_BITS   = 2
);
  logic                 CKE;
  logic [NUM_RANKS-1:0] CS_n;
  logic                 ACT_n;
  logic                 RAS_n_A16;
  logic                 CAS_n_A15;
  logic                 WE_n_A14;
  logic [BG_BITS-1:0]   BG;
  logic [BA_BITS-1:0]   BA;
  logic [13:0]          ADDR;
  logic                 ADDR_17;
  logic                 PARITY;

  modport master (output CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
                         BG, BA, ADDR, ADDR_17, PARITY);
  modport slave  (input  CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
                         BG, BA, ADDR, ADDR_17, PARITY);
endinterface

// File: rtl/ddr4_bank_monitor.sv
// Passive DDR4 CA-bus monitor: per-bank state/timers, command counters, first-error capture.
// Optional CA parity checking is enabled by defining DDR4_MON_PARITY_EN.
module ddr4_bank_fsm #(
  parameter int T_RCD = 16,
  parameter int T_RAS = 39,
  parameter int T_RP  = 16,
  parameter int TMAX  = 39,
  parameter int TW    = 6
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic hit_act,
  input  logic hit_pre,
  output logic active,
  output logic idle,
  output logic rcd_ok,
  output logic ras_ok
);
  typedef enum logic [1:0] {IDLE, ACTIVE, PRECH} st_t;
  st_t           state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic          rp_done;

  assign rp_done = (state == PRECH) && (tmr >= TW'(T_RP));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state <= IDLE;
      tmr   <= TW'(TMAX);
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tmr_nx   = (tmr == TW'(TMAX)) ? tmr : tmr + TW'(1);
    if (rp_done) state_nx = IDLE;
    // Precharge of a bank that is not open is a legal no-op.
    if (hit_act) begin
      state_nx = ACTIVE;
      tmr_nx   = '0;
    end else if (hit_pre && state == ACTIVE) begin
      state_nx = PRECH;
      tmr_nx   = '0;
    end
  end

  assign active = (state == ACTIVE);
  assign idle   = (state == IDLE) || rp_done;
  assign rcd_ok = (tmr >= TW'(T_RCD));
  assign ras_ok = (tmr >= TW'(T_RAS));
endmodule

module ddr4_bank_monitor #(
  parameter int NUM_RANKS = 1,
  parameter int BG_BITS   = 1,
  parameter int BA_BITS   = 2,
  parameter int T_RCD     = 16,
  parameter int T_RAS     = 39,
  parameter int T_RP      = 16,
  parameter int CNT_W     = 32
) (
  input  logic                                         CK,
  input  logic                                         RESET_n,
  ddr4_bank_monitor_if.slave                           ca,
  input  logic                                         clr_i,
  output logic                                         err_o,
  output logic [2:0]                                   err_code_o,
  output logic [1:0]                                   err_rank_o,
  output logic [BG_BITS+BA_BITS-1:0]                   err_bank_o,
  output logic [CNT_W-1:0]                             err_cnt_o,
  output logic [CNT_W-1:0]                             act_cnt_o,
  output logic [CNT_W-1:0]                             rd_cnt_o,
  output logic [CNT_W-1:0]                             wr_cnt_o,
  output logic [CNT_W-1:0]                             pre_cnt_o,
  output logic [CNT_W-1:0]                             ref_cnt_o,
  output logic [NUM_RANKS*(2**(BG_BITS+BA_BITS))-1:0] open_o
);
  localparam int BK_W = BG_BITS + BA_BITS;
  localparam int NB   = 2 ** BK_W;
  localparam int NBT  = NUM_RANKS * NB;
  localparam int TMAX = (T_RAS > T_RP) ? ((T_RAS > T_RCD) ? T_RAS : T_RCD)
                                       : ((T_RP  > T_RCD) ? T_RP  : T_RCD);
  localparam int TW   = $clog2(TMAX + 1);

  logic [NUM_RANKS-1:0] cs;
  logic [1:0]           rank;
  logic [BK_W-1:0]      bank, pre_bank, ebank;
  logic [2:0]           rcw, ecode;
  logic                 vld, multi, par_err, viol;
  logic                 is_act, is_ref, is_pre, is_rd, is_wr, is_rw, is_rfu;
  logic [NBT-1:0]       active_v, idle_v, rcd_v, ras_v, v1, v2, v3, v4, v6;

  assign cs    = ~ca.CS_n;
  assign vld   = ca.CKE && ($countones(cs) == 1);
  assign multi = ca.CKE && ($countones(cs) > 1);
  assign bank  = {ca.BG, ca.BA};
  assign rcw   = {ca.RAS_n_A16, ca.CAS_n_A15, ca.WE_n_A14};

  always_comb begin
    rank = '0;
    for (int i = NUM_RANKS - 1; i >= 0; i--) if (cs[i]) rank = 2'(i);
  end

  assign is_act = vld && !ca.ACT_n;
  assign is_ref = vld && ca.ACT_n && (rcw == 3'b001);
  assign is_pre = vld && ca.ACT_n && (rcw == 3'b010);
  assign is_wr  = vld && ca.ACT_n && (rcw == 3'b100);
  assign is_rd  = vld && ca.ACT_n && (rcw == 3'b101);
  assign is_rfu = vld && ca.ACT_n && (rcw == 3'b011);
  assign is_rw  = is_rd || is_wr;

`ifdef DDR4_MON_PARITY_EN
  assign par_err = vld && ^{ca.ACT_n, rcw, ca.BG, ca.BA, ca.ADDR_17, ca.ADDR, ca.PARITY};
`else
  logic unused_ok;
  assign unused_ok = ^{ca.ADDR, ca.ADDR_17, ca.PARITY};
  assign par_err   = 1'b0;
`endif

  for (genvar g = 0; g < NBT; g++) begin : g_bank
    localparam int R = g / NB;
    localparam int B = g % NB;
    logic rank_hit, bank_hit, pre_hit;
    assign rank_hit = vld && (rank == 2'(R));
    assign bank_hit = rank_hit && (bank == BK_W'(B));
    assign pre_hit  = is_pre && (ca.ADDR[10] ? rank_hit : bank_hit);

    ddr4_bank_fsm #(.T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP), .TMAX(TMAX), .TW(TW)) u_bank (
      .gclk   (CK),
      .grst_n (RESET_n),
      .hit_act(is_act && bank_hit),
      .hit_pre(pre_hit || (is_rw && ca.ADDR[10] && bank_hit)),
      .active (active_v[g]),
      .idle   (idle_v[g]),
      .rcd_ok (rcd_v[g]),
      .ras_ok (ras_v[g])
    );

    assign v1[g] = is_act && bank_hit && !idle_v[g];
    assign v2[g] = is_rw  && bank_hit && !active_v[g];
    assign v3[g] = is_rw  && bank_hit && active_v[g] && !rcd_v[g];
    assign v4[g] = pre_hit && active_v[g] && !ras_v[g];
    assign v6[g] = is_ref && rank_hit && !idle_v[g];
  end

  assign open_o = active_v;

  // PREA may trip tRAS on several banks; report the lowest one.
  always_comb begin
    pre_bank = bank;
    for (int g = NBT - 1; g >= 0; g--) if (v4[g]) pre_bank = BK_W'(g);
  end

  always_comb begin
    ecode = 3'd0;
    if      (par_err) ecode = 3'd0;
    else if (|v1)     ecode = 3'd1;
    else if (|v2)     ecode = 3'd2;
    else if (|v3)     ecode = 3'd3;
    else if (|v4)     ecode = 3'd4;
    else if (multi)   ecode = 3'd5;
    else if (|v6)     ecode = 3'd6;
    else if (is_rfu)  ecode = 3'd7;
    viol  = par_err || |v1 || |v2 || |v3 || |v4 || multi || |v6 || is_rfu;
    ebank = (ecode == 3'd4) ? pre_bank : bank;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && !(&c)) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge CK or negedge RESET_n) begin
    if (!RESET_n || clr_i) begin
      // Clear beats a coincident violation: the capture and counters both restart.
      err_o      <= 1'b0;
      err_code_o <= '0;
      err_rank_o <= '0;
      err_bank_o <= '0;
      err_cnt_o  <= '0;
      act_cnt_o  <= '0;
      rd_cnt_o   <= '0;
      wr_cnt_o   <= '0;
      pre_cnt_o  <= '0;
      ref_cnt_o  <= '0;
    end else begin
      if (viol && !err_o) begin
        err_o      <= 1'b1;
        err_code_o <= ecode;
        err_rank_o <= rank;
        err_bank_o <= ebank;
      end
      err_cnt_o <= sat_inc(err_cnt_o, viol);
      act_cnt_o <= sat_inc(act_cnt_o, is_act);
      rd_cnt_o  <= sat_inc(rd_cnt_o,  is_rd);
      wr_cnt_o  <= sat_inc(wr_cnt_o,  is_wr);
      pre_cnt_o <= sat_inc(pre_cnt_o, is_pre);
      ref_cnt_o <= sat_inc(ref_cnt_o, is_ref);
    end
  end
endmodule

// File: tb/tb_ddr4_bank_monitor.sv
// Directed bench for ddr4_bank_monitor (2 ranks); expected snapshots are queued
// when each command is driven and compared after the registered update.
module tb_ddr4_bank_monitor;
  logic        CK, RESET_n, clr_i;
  logic        err_o;
  logic [2:0]  err_code_o;
  logic [1:0]  err_rank_o;
  logic [2:0]  err_bank_o;
  logic [31:0] err_cnt_o, act_cnt_o, rd_cnt_o, wr_cnt_o, pre_cnt_o, ref_cnt_o;
  logic [15:0] open_o;

  ddr4_bank_monitor_if #(.NUM_RANKS(2), .BG_BITS(1), .BA_BITS(2)) ca ();

  ddr4_bank_monitor #(.NUM_RANKS(2), .BG_BITS(1), .BA_BITS(2),
                      .T_RCD(16), .T_RAS(39), .T_RP(16), .CNT_W(32)) dut (
    .CK(CK), .RESET_n(RESET_n), .ca(ca), .clr_i(clr_i),
    .err_o(err_o), .err_code_o(err_code_o), .err_rank_o(err_rank_o),
    .err_bank_o(err_bank_o), .err_cnt_o(err_cnt_o), .act_cnt_o(act_cnt_o),
    .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o), .pre_cnt_o(pre_cnt_o),
    .ref_cnt_o(ref_cnt_o), .open_o(open_o)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  localparam logic [2:0] C_REF = 3'b001, C_PRE = 3'b010, C_WR = 3'b100,
                         C_RD  = 3'b101, C_RFU = 3'b011, C_NOP = 3'b111;

  typedef struct {
    string       tag;
    logic        err;
    logic [2:0]  code;
    logic [1:0]  rank;
    logic [2:0]  bank;
    logic [31:0] errc, act, rd, wr, pre, rf;
    logic [15:0] open;
  } snap_t;

  snap_t e;
  snap_t q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string tag, input string fld, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, got, exp);
    end
  endtask

  task automatic compare();
    snap_t s;
    s = q.pop_front();
    chk(s.tag, "err",  32'(err_o),      32'(s.err));
    chk(s.tag, "code", 32'(err_code_o), 32'(s.code));
    chk(s.tag, "rank", 32'(err_rank_o), 32'(s.rank));
    chk(s.tag, "bank", 32'(err_bank_o), 32'(s.bank));
    chk(s.tag, "errc", err_cnt_o, s.errc);
    chk(s.tag, "act",  act_cnt_o, s.act);
    chk(s.tag, "rd",   rd_cnt_o,  s.rd);
    chk(s.tag, "wr",   wr_cnt_o,  s.wr);
    chk(s.tag, "pre",  pre_cnt_o, s.pre);
    chk(s.tag, "ref",  ref_cnt_o, s.rf);
    chk(s.tag, "open", 32'(open_o), 32'(s.open));
  endtask

  task automatic nop_bus();
    ca.CKE = 1'b1; ca.CS_n = 2'b11; ca.ACT_n = 1'b1;
    {ca.RAS_n_A16, ca.CAS_n_A15, ca.WE_n_A14} = C_NOP;
    ca.BG = '0; ca.BA = '0; ca.ADDR = '0; ca.ADDR_17 = 1'b0; ca.PARITY = 1'b0;
    clr_i = 1'b0;
  endtask

  task automatic cmd(input string tag, input logic cke, input logic [1:0] csn, input logic actn,
                     input logic [2:0] rcw, input logic [2:0] bk, input logic a10,
                     input logic clr, input logic badpar);
    ca.CKE = cke; ca.CS_n = csn; ca.ACT_n = actn;
    {ca.RAS_n_A16, ca.CAS_n_A15, ca.WE_n_A14} = rcw;
    {ca.BG, ca.BA} = bk;
    ca.ADDR = '0; ca.ADDR[10] = a10; ca.ADDR_17 = 1'b0;
    ca.PARITY = (^{actn, rcw, bk, 1'b0, a10}) ^ badpar;
    clr_i = clr;
    e.tag = tag;
    q.push_back(e);
    @(posedge CK);
    #1;
    nop_bus();
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  task automatic clear_exp();
    e.err = 0; e.code = 0; e.rank = 0; e.bank = 0;
    e.errc = 0; e.act = 0; e.rd = 0; e.wr = 0; e.pre = 0; e.rf = 0;
  endtask

  initial begin
    clear_exp();
    e.open = '0;
    nop_bus();
    RESET_n = 1'b0;
    #2;
    e.tag = "reset"; q.push_back(e); compare();
    #20;
    RESET_n = 1'b1;
    @(posedge CK); #1;

    // Legal ACT -> RD -> PRE on rank 0 bank 1
    e.act = 1; e.open[1] = 1;
    cmd("act_b1", 1, 2'b10, 0, C_NOP, 3'd1, 0, 0, 0);
    idle(16);
    e.rd = 1;
    cmd("rd_b1", 1, 2'b10, 1, C_RD, 3'd1, 0, 0, 0);
    idle(23);
    e.pre = 1; e.open[1] = 0;
    cmd("pre_b1", 1, 2'b10, 1, C_PRE, 3'd1, 0, 0, 0);

    // tRCD violation
    e.act = 2; e.open[0] = 1;
    cmd("act_b0", 1, 2'b10, 0, C_NOP, 3'd0, 0, 0, 0);
    idle(4);
    e.rd = 2; e.err = 1; e.code = 3; e.bank = 0; e.errc = 1;
    cmd("rcd_viol", 1, 2'b10, 1, C_RD, 3'd0, 0, 0, 0);

    // ACT to an already open bank
    clear_exp();
    cmd("clr1", 1, 2'b11, 1, C_NOP, 3'd0, 0, 1, 0);
    e.act = 1; e.open[2] = 1;
    cmd("act_b2", 1, 2'b10, 0, C_NOP, 3'd2, 0, 0, 0);
    e.act = 2; e.err = 1; e.code = 1; e.bank = 2; e.errc = 1;
    cmd("act_twice", 1, 2'b10, 0, C_NOP, 3'd2, 0, 0, 0);

    // REF with open banks, then PREA and a clean REF
    clear_exp();
    cmd("clr2", 1, 2'b11, 1, C_NOP, 3'd0, 0, 1, 0);
    e.act = 1; e.open[3] = 1;
    cmd("act_b3", 1, 2'b10, 0, C_NOP, 3'd3, 0, 0, 0);
    idle(49);
    e.rf = 1; e.err = 1; e.code = 6; e.bank = 0; e.errc = 1;
    cmd("ref_open", 1, 2'b10, 1, C_REF, 3'd0, 0, 0, 0);
    e.pre = 1; e.open[0] = 0; e.open[2] = 0; e.open[3] = 0;
    cmd("prea", 1, 2'b10, 1, C_PRE, 3'd0, 1, 0, 0);
    idle(16);
    e.rf = 2;
    cmd("ref_ok", 1, 2'b10, 1, C_REF, 3'd0, 0, 0, 0);

    // Two chip selects low, then clear
    clear_exp();
    cmd("clr3", 1, 2'b11, 1, C_NOP, 3'd0, 0, 1, 0);
    e.err = 1; e.code = 5; e.rank = 0; e.bank = 1; e.errc = 1;
    cmd("multi_cs", 1, 2'b00, 0, C_NOP, 3'd1, 0, 0, 0);
    clear_exp();
    cmd("clr4", 1, 2'b11, 1, C_NOP, 3'd0, 0, 1, 0);

    // Rank 1: RFU captured, later tRAS violation only counted
    e.act = 1; e.open[12] = 1;
    cmd("act_r1b4", 1, 2'b01, 0, C_NOP, 3'd4, 0, 0, 0);
    e.err = 1; e.code = 7; e.rank = 1; e.bank = 4; e.errc = 1;
    cmd("rfu_r1", 1, 2'b01, 1, C_RFU, 3'd4, 0, 0, 0);
    idle(2);
    e.pre = 1; e.errc = 2; e.open[12] = 0;
    cmd("ras_viol", 1, 2'b01, 1, C_PRE, 3'd4, 0, 0, 0);

    // Clear coinciding with a violation: clear wins
    clear_exp();
    cmd("clr_vs_viol", 1, 2'b10, 1, C_RD, 3'd1, 0, 1, 0);

    // CKE low ignored; WR with auto-precharge; RD into precharging bank
    cmd("cke_low", 0, 2'b10, 0, C_NOP, 3'd6, 0, 0, 0);
    e.act = 1; e.open[1] = 1;
    cmd("act_b1b", 1, 2'b10, 0, C_NOP, 3'd1, 0, 0, 0);
    idle(16);
    e.wr = 1; e.open[1] = 0;
    cmd("wr_ap", 1, 2'b10, 1, C_WR, 3'd1, 1, 0, 0);
    e.rd = 1; e.err = 1; e.code = 2; e.bank = 1; e.errc = 1;
    cmd("rd_prech", 1, 2'b10, 1, C_RD, 3'd1, 0, 0, 0);

    // Asynchronous reset between edges
    #2;
    RESET_n = 1'b0;
    #1;
    clear_exp(); e.open = '0;
    e.tag = "async_rst"; q.push_back(e); compare();
    @(posedge CK); #1;
    RESET_n = 1'b1;
    @(posedge CK); #1;

`ifdef DDR4_MON_PARITY_EN
    e.err = 1; e.code = 0; e.rank = 0; e.bank = 0; e.errc = 1;
    cmd("bad_parity", 1, 2'b10, 1, C_NOP, 3'd0, 0, 0, 1);
`else
    cmd("parity_off", 1, 2'b10, 1, C_NOP, 3'd0, 0, 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
